uart_periph: RTL and testbench
==============================

UART_PERIPH -- requirements
Module: uart_periph

Interface
REQ-001 Parameter BAUD_DIV, default 326, meaning clk cycles per 16x-oversample tick (50 MHz / 9600 baud / 16).
REQ-002 Parameter BASE, default 32'h40000018, meaning address of the TXD register; RXD is BASE+4 and CON is BASE+8.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low.
REQ-005 addr  input  32  byte address from the MEM-stage bus.
REQ-006 rd  input  1  read strobe, one cycle per access.
REQ-007 wr  input  1  write strobe, one cycle per access.
REQ-008 wdata  input  32  write data.
REQ-009 rdata  output  32  read data, combinational.
REQ-010 rx  input  1  serial line in, asynchronous to clk.
REQ-011 tx  output  1  serial line out, idle high.
REQ-012 irq  output  1  level interrupt request to the CPU.

Function
REQ-013 Tick generator: counter 0..BAUD_DIV-1 that pulses tick for one clk on wrap.
REQ-014 Frame format: 8N1, LSB first, 16 ticks per bit.
REQ-015 TXD write (wr, addr==BASE) while TX is IDLE latches wdata[7:0] and starts a frame; the same write while TX is busy is ignored.
REQ-016 TX FSM states: IDLE -> START (tx=0) -> DATA (bits 0..7) -> STOP (tx=1) -> IDLE.
  - Each state is held for 16 ticks.
  - Leaving STOP sets tx_done.
REQ-017 rx passes through a 2-flop synchronizer before any use.
REQ-018 RX FSM, IDLE state: a synchronized falling edge enters START and clears the tick-phase counter.
REQ-019 RX FSM, START state: at the 8th tick, rx low enters DATA; rx high returns to IDLE (glitch rejection).
REQ-020 RX FSM, DATA state: samples one bit every 16 ticks, 8 bits total, then enters STOP.
REQ-021 RX FSM, STOP state: sampled 16 ticks after the last data bit.
  - High: load rx_data and set rx_valid; if rx_valid was already 1, also set overrun.
  - Low: set frame_err, discard the byte, leave rx_valid unchanged.
  - Both cases return to IDLE.
REQ-022 CON register bits:
  - [0] tx_irq_en, R/W.
  - [1] rx_irq_en, R/W.
  - [2] tx_done, R, clear-on-read.
  - [3] rx_valid, RO.
  - [4] tx_busy, RO.
  - [5] frame_err, R, clear-on-read.
  - [6] overrun, R, clear-on-read.
  - [31:7] read as 0.
  - A CON write affects only bits [1:0].
REQ-023 rdata contents when rd=1:
  - TXD address: {24'b0, last TX byte}.
  - RXD address: {24'b0, rx_data}.
  - CON address: {25'b0, status}.
  - rdata=0 when rd=0 or the address is unmapped.
REQ-024 A read of RXD clears rx_valid at the next clk edge.
REQ-025 A read of CON clears tx_done, frame_err and overrun at the next clk edge.
REQ-026 Simultaneous set and clear of any flag in one cycle: set wins.
REQ-027 irq = (tx_irq_en & tx_done) | (rx_irq_en & rx_valid), combinational from registered state.
REQ-028 TX and RX operate independently; full-duplex traffic shall not interfere.
REQ-029 Unmapped writes shall not change any state.

Reset
REQ-030 Reset asserted (reset=0) forces, immediately and regardless of clk:
  - tx=1, rdata=0 (combinational), irq=0.
  - TX and RX FSMs to IDLE.
  - Tick, phase and bit counters to 0.
  - TX byte, rx_data and all CON bits to 0.
REQ-031 Reset mid-frame aborts the frame; after release tx stays 1 until a new TXD write.

Verification
REQ-032 BAUD_DIV=4; write TXD 32'h000000A5 -> tx low for 64 clk, then bits 1,0,1,0,0,1,0,1 at 64 clk each, stop high; CON[2]=1 afterwards.
REQ-033 Write 8'h3C to TXD, then write 8'h FF to TXD at clk 10 of the same frame -> the frame still carries 8'h3C; the 8'hFF write has no effect.
REQ-034 CON=32'h2; drive rx with a frame of 8'h5A -> RXD reads 32'h5A; irq=1 until the RXD read; irq=0 the cycle after.
REQ-035 Drive two frames (8'h11, 8'h22) without reading -> RXD=32'h22; CON[6]=1; CON read returns bit6=1, and the next CON read returns bit6=0.
REQ-036 rx frame with a low stop bit -> CON[5]=1, rx_valid unchanged; a 3-tick low glitch on rx -> no flags set.
REQ-037 reset=0 halfway through the TX data bits -> tx=1 immediately; after release CON reads 32'h0.

Source files
------------

// File: rtl/uart_periph.sv
// UART peripheral on the MEM-stage bus: TXD / RXD / CON registers,
// 8N1 framing with 16x oversampling, level interrupt to the CPU.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   addr   byte address from the MEM-stage bus
//   rd     read strobe, one cycle per access
//   wr     write strobe, one cycle per access
//   wdata  write data
//   rdata  read data, combinational, 0 when idle or unmapped
//   rx     serial line in, asynchronous to clk
//   tx     serial line out, idle high
//   irq    level interrupt request
module uart_periph #(
    parameter int          BAUD_DIV = 326,
    parameter logic [31:0] BASE     = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);

    localparam int TICK_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [31:0] TXD_ADDR = BASE;
    localparam logic [31:0] RXD_ADDR = BASE + 32'd4;
    localparam logic [31:0] CON_ADDR = BASE + 32'd8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // ------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------
    logic sel_txd;
    logic sel_rxd;
    logic sel_con;
    logic txd_wr;
    logic con_wr;
    logic rxd_rd;
    logic con_rd;

    assign sel_txd = (addr == TXD_ADDR);
    assign sel_rxd = (addr == RXD_ADDR);
    assign sel_con = (addr == CON_ADDR);
    assign txd_wr  = wr & sel_txd;
    assign con_wr  = wr & sel_con;
    assign rxd_rd  = rd & sel_rxd;
    assign con_rd  = rd & sel_con;

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    // ------------------------------------------------------------
    // 16x oversample tick
    // ------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    assign tick = (tick_cnt == TICK_W'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------
    tx_state_t  tx_state;
    tx_state_t  tx_next;
    logic [3:0] tx_phase;
    logic [2:0] tx_bit;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_phase_end;
    logic       tx_done_set;
    logic       tx_line;
    logic       tx_busy;

    // Writes while a frame is in flight are dropped here.
    assign tx_start     = txd_wr && (tx_state == TX_IDLE);
    assign tx_phase_end = tick && (tx_phase == 4'd15);
    assign tx_done_set  = (tx_state == TX_STOP) && tx_phase_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: begin
                if (tx_start) tx_next = TX_START;
            end
            TX_START: begin
                if (tx_phase_end) tx_next = TX_DATA;
            end
            TX_DATA: begin
                if (tx_phase_end && (tx_bit == 3'd7))
                    tx_next = TX_STOP;
            end
            TX_STOP: begin
                if (tx_phase_end) tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_line = 1'b1;
        tx_busy = 1'b1;
        case (tx_state)
            TX_IDLE:  tx_busy = 1'b0;
            TX_START: tx_line = 1'b0;
            TX_DATA:  tx_line = tx_byte[tx_bit];
            TX_STOP:  tx_line = 1'b1;
            default: begin
                tx_line = 1'b1;
                tx_busy = 1'b0;
            end
        endcase
    end

    assign tx = tx_line;

    // Phase restarts at 0 on every frame so each bit is 16 ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_phase <= '0;
            tx_bit   <= '0;
        end else if (tx_state == TX_IDLE) begin
            tx_phase <= '0;
            tx_bit   <= '0;
        end else if (tick) begin
            tx_phase <= tx_phase + 4'd1;
            if ((tx_state == TX_DATA) && (tx_phase == 4'd15))
                tx_bit <= tx_bit + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_byte <= '0;
        end else if (tx_start) begin
            tx_byte <= wdata[7:0];
        end
    end

    // ------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------
    logic       rx_s1;
    logic       rx_s2;
    logic       rx_s3;
    logic       rx_fall;
    rx_state_t  rx_state;
    rx_state_t  rx_next;
    logic [3:0] rx_phase;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;
    logic [7:0] rx_data;
    logic       rx_mid;
    logic       rx_sample;
    logic       rx_stop;
    logic       rx_good;
    logic       rx_bad;

    // rx_s1/rx_s2 form the synchronizer; rx_s3 only serves edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_fall   = rx_s3 & ~rx_s2;
    assign rx_mid    = tick && (rx_phase == 4'd7);
    assign rx_sample = tick && (rx_phase == 4'd15);
    assign rx_stop   = (rx_state == RX_STOP) && rx_sample;
    assign rx_good   = rx_stop & rx_s2;
    assign rx_bad    = rx_stop & ~rx_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) rx_next = RX_START;
            end
            RX_START: begin
                // Line back high at mid start bit: treat as a glitch.
                if (rx_mid) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_sample && (rx_bit == 3'd7))
                    rx_next = RX_STOP;
            end
            RX_STOP: begin
                if (rx_sample) rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // Phase is re-zeroed at mid start bit, so later samples at
    // phase 15 land in the middle of each data and stop bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_phase <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_phase <= '0;
                    rx_bit   <= '0;
                end
                RX_START: begin
                    if (rx_mid) begin
                        rx_phase <= '0;
                    end else if (tick) begin
                        rx_phase <= rx_phase + 4'd1;
                    end
                end
                RX_DATA: begin
                    if (tick) rx_phase <= rx_phase + 4'd1;
                    if (rx_sample) begin
                        rx_bit   <= rx_bit + 3'd1;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                    end
                end
                RX_STOP: begin
                    if (tick) rx_phase <= rx_phase + 4'd1;
                end
                default: begin
                    rx_phase <= '0;
                    rx_bit   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data <= '0;
        end else if (rx_good) begin
            rx_data <= rx_shift;
        end
    end

    // ------------------------------------------------------------
    // CON register and status flags (set wins over clear)
    // ------------------------------------------------------------
    logic       tx_irq_en;
    logic       rx_irq_en;
    logic       tx_done;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic [6:0] status;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_irq_en <= 1'b0;
            rx_irq_en <= 1'b0;
        end else if (con_wr) begin
            tx_irq_en <= wdata[0];
            rx_irq_en <= wdata[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_done   <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (tx_done_set) tx_done <= 1'b1;
            else if (con_rd) tx_done <= 1'b0;

            if (rx_good)     rx_valid <= 1'b1;
            else if (rxd_rd) rx_valid <= 1'b0;

            if (rx_bad)      frame_err <= 1'b1;
            else if (con_rd) frame_err <= 1'b0;

            if (rx_good && rx_valid) overrun <= 1'b1;
            else if (con_rd)         overrun <= 1'b0;
        end
    end

    assign status = {overrun, frame_err, tx_busy, rx_valid,
                     tx_done, rx_irq_en, tx_irq_en};

    assign irq = (tx_irq_en & tx_done) | (rx_irq_en & rx_valid);

    // ------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------
    always_comb begin
        rdata = '0;
        if (reset && rd) begin
            unique case (1'b1)
                sel_txd: rdata = {24'b0, tx_byte};
                sel_rxd: rdata = {24'b0, rx_data};
                sel_con: rdata = {25'b0, status};
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_periph.sv
// Directed testbench for uart_periph with BAUD_DIV=4 (64 clk per bit).
module tb_uart_periph;

    localparam logic [31:0] BASE = 32'h40000018;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] RXD  = BASE + 32'd4;
    localparam logic [31:0] CON  = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rx = 1'b1;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    uart_periph #(
        .BAUD_DIV(4),
        .BASE    (BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .rd   (rd),
        .wr   (wr),
        .wdata(wdata),
        .rdata(rdata),
        .rx   (rx),
        .tx   (tx),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        wdata = d;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        addr = '0;
        wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        rd = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        rd = 1'b0;
        addr = '0;
    endtask

    task automatic wait_tx_fall(output bit to);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (tx === 1'b0) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Samples the frame at mid-bit; optional TXD write of 8'hFF 10 clk in.
    task automatic capture_tx(input bit inject, output logic [7:0] b,
                              output logic st, output logic sp,
                              output bit to);
        b = '0;
        st = 1'b1;
        sp = 1'b0;
        wait_tx_fall(to);
        if (!to) begin
            if (inject) begin
                repeat (8) @(negedge clk);
                bus_write(TXD, 32'h000000FF);
                repeat (22) @(negedge clk);
            end else begin
                repeat (32) @(negedge clk);
            end
            st = tx;
            for (int k = 0; k < 8; k++) begin
                repeat (64) @(negedge clk);
                b[k] = tx;
            end
            repeat (64) @(negedge clk);
            sp = tx;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic sp);
        @(negedge clk);
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (64) @(negedge clk);
        end
        rx = sp;
        repeat (64) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        @(negedge clk);
        addr = CON;
        rd = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b expected 1", tx);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        rd = 1'b0;
        addr = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus_read(CON, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_con: got %h expected 0", d);
        end
        bus_read(RXD, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_rxd: got %h expected 0", d);
        end
    endtask

    task automatic test_unmapped;
        logic [31:0] d;
        bus_write(BASE + 32'd12, 32'hFFFFFFFF);
        bus_write(BASE - 32'd4, 32'hFFFFFFFF);
        bus_read(CON, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_con: got %h expected 0", d);
        end
        bus_read(BASE + 32'd12, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_rd: got %h expected 0", d);
        end
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_tx: got %b expected 1", tx);
        end
        @(negedge clk);
        addr = TXD;
        rd = 1'b0;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL rd_low_rdata: got %h expected 0", rdata);
        end
        addr = '0;
    endtask

    task automatic test_tx_a5;
        logic [7:0] b;
        logic st, sp;
        bit to;
        logic [31:0] d;
        bus_write(TXD, 32'h000000A5);
        capture_tx(1'b0, b, st, sp, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL tx_a5_timeout: no start bit within 200 clk");
        end
        checks++;
        if ({st, b, sp} !== {1'b0, 8'hA5, 1'b1}) begin
            errors++;
            $display("FAIL tx_a5_frame: got st=%b data=%h sp=%b expected st=0 data=a5 sp=1",
                     st, b, sp);
        end
        repeat (40) @(negedge clk);
        bus_read(CON, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL tx_a5_con: got %h expected 4", d);
        end
        bus_read(CON, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL tx_done_clr: got %h expected 0", d);
        end
    endtask

    task automatic test_tx_busy_ignore;
        logic [7:0] b;
        logic st, sp;
        bit to;
        logic [31:0] d;
        bus_write(TXD, 32'h0000003C);
        capture_tx(1'b1, b, st, sp, to);
        checks++;
        if (to || {st, b, sp} !== {1'b0, 8'h3C, 1'b1}) begin
            errors++;
            $display("FAIL tx_busy_frame: got to=%b st=%b data=%h sp=%b expected data=3c",
                     to, st, b, sp);
        end
        bus_read(TXD, d);
        checks++;
        if (d !== 32'h3C) begin
            errors++;
            $display("FAIL tx_busy_txd: got %h expected 3c", d);
        end
        repeat (40) @(negedge clk);
        bus_read(CON, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL tx_busy_con: got %h expected 4", d);
        end
    endtask

    task automatic test_rx_irq;
        logic [31:0] d;
        bus_write(CON, 32'h2);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL rx_irq_pre: got %b expected 0", irq);
        end
        send_rx(8'h5A, 1'b1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL rx_irq_set: got %b expected 1", irq);
        end
        bus_read(CON, d);
        checks++;
        if (d !== 32'h0A) begin
            errors++;
            $display("FAIL rx_con: got %h expected 0a", d);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL rx_irq_hold: got %b expected 1", irq);
        end
        bus_read(RXD, d);
        checks++;
        if (d !== 32'h5A) begin
            errors++;
            $display("FAIL rx_data: got %h expected 5a", d);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL rx_irq_clr: got %b expected 0", irq);
        end
    endtask

    task automatic test_overrun;
        logic [31:0] d;
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_read(CON, d);
        checks++;
        if (d !== 32'h4A) begin
            errors++;
            $display("FAIL ovr_con1: got %h expected 4a", d);
        end
        bus_read(CON, d);
        checks++;
        if (d !== 32'h0A) begin
            errors++;
            $display("FAIL ovr_con2: got %h expected 0a", d);
        end
        bus_read(RXD, d);
        checks++;
        if (d !== 32'h22) begin
            errors++;
            $display("FAIL ovr_rxd: got %h expected 22", d);
        end
    endtask

    task automatic test_frame_err;
        logic [31:0] d;
        send_rx(8'h33, 1'b1);
        send_rx(8'h77, 1'b0);
        bus_read(CON, d);
        checks++;
        if (d !== 32'h2A) begin
            errors++;
            $display("FAIL ferr_con: got %h expected 2a", d);
        end
        bus_read(RXD, d);
        checks++;
        if (d !== 32'h33) begin
            errors++;
            $display("FAIL ferr_rxd: got %h expected 33", d);
        end
        bus_read(CON, d);
        checks++;
        if (d !== 32'h02) begin
            errors++;
            $display("FAIL ferr_clr: got %h expected 02", d);
        end
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        @(negedge clk);
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (1200) @(negedge clk);
        bus_read(CON, d);
        checks++;
        if (d !== 32'h02) begin
            errors++;
            $display("FAIL glitch_con: got %h expected 02", d);
        end
        bus_read(RXD, d);
        checks++;
        if (d !== 32'h33) begin
            errors++;
            $display("FAIL glitch_rxd: got %h expected 33", d);
        end
    endtask

    task automatic test_full_duplex;
        logic [7:0] b;
        logic st, sp;
        bit to;
        logic [31:0] d;
        fork
            begin
                bus_write(TXD, 32'h000000C3);
                capture_tx(1'b0, b, st, sp, to);
            end
            send_rx(8'h96, 1'b1);
        join
        repeat (40) @(negedge clk);
        checks++;
        if (to || {st, b, sp} !== {1'b0, 8'hC3, 1'b1}) begin
            errors++;
            $display("FAIL fdx_tx: got to=%b st=%b data=%h sp=%b expected data=c3",
                     to, st, b, sp);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL fdx_irq: got %b expected 1", irq);
        end
        bus_read(CON, d);
        checks++;
        if (d !== 32'h0E) begin
            errors++;
            $display("FAIL fdx_con: got %h expected 0e", d);
        end
        bus_read(RXD, d);
        checks++;
        if (d !== 32'h96) begin
            errors++;
            $display("FAIL fdx_rxd: got %h expected 96", d);
        end
    endtask

    task automatic test_reset_mid;
        bit to;
        int lows;
        logic [31:0] d;
        bus_write(CON, 32'h3);
        bus_write(TXD, 32'h000000F0);
        wait_tx_fall(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL rst_mid_timeout: no start bit within 200 clk");
        end
        repeat (32 + 64 * 4) @(negedge clk);
        reset = 1'b0;
        addr = CON;
        rd = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || irq !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_now: got tx=%b irq=%b rdata=%h expected 1 0 0",
                     tx, irq, rdata);
        end
        rd = 1'b0;
        addr = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL rst_mid_idle: got %0d low samples expected 0", lows);
        end
        bus_read(CON, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_con: got %h expected 0", d);
        end
        bus_read(TXD, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_txd: got %h expected 0", d);
        end
    endtask

    initial begin
        test_reset();
        test_unmapped();
        test_tx_a5();
        test_tx_busy_ignore();
        test_rx_irq();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_full_duplex();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
